demux_rr_sched: RTL and testbench



---
 rtl/demux_rr_sched.sv | 121 ++++++++++++
 tb/tb_demux_rr_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// Sequencing controller for a 1-to-8 demux: captures one word, arbitrates a channel
// (round-robin over enabled channels or addressed), then holds it until that channel accepts.
module demux_rr_sched #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    input  logic [2:0]    i_in_sel,
    input  logic          i_mode,
    input  logic [7:0]    i_ch_mask,
    input  logic [7:0]    i_ch_ready,
    output logic [7:0]    o_out_valid,
    output logic [DW-1:0] o_out_data,
    output logic [2:0]    o_sel,
    output logic          o_en,
    output logic          o_busy,
    output logic [7:0]    o_err_cnt
);

    typedef enum logic [1:0] {StIdle, StArb, StSend} state_e;

    state_e        r_state;
    logic [2:0]    r_rr_ptr;
    logic [2:0]    r_hsel;
    logic          r_mode;
    logic [DW-1:0] r_data;
    logic [2:0]    r_sel;
    logic [DW-1:0] r_out_data;
    logic [7:0]    r_out_valid;
    logic          r_en;
    logic [7:0]    r_err_cnt;

    logic [7:0]    w_rot;
    logic [2:0]    w_off;
    logic [2:0]    w_grant;
    logic [2:0]    w_tgt;
    logic          w_ok;

    // Mask rotated so that bit 0 corresponds to the round-robin pointer.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < 8; i++) begin
            w_rot[i] = i_ch_mask[r_rr_ptr + 3'(i)];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_grant = r_rr_ptr + w_off;
    assign w_tgt   = r_mode ? r_hsel : w_grant;
    assign w_ok    = r_mode ? i_ch_mask[r_hsel] : (|i_ch_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_hsel      <= '0;
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_sel       <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_en        <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_data  <= i_in_data;
                        r_hsel  <= i_in_sel;
                        r_mode  <= i_mode;
                        r_state <= StArb;
                    end
                end
                StArb: begin
                    if (w_ok) begin
                        r_sel       <= w_tgt;
                        r_out_data  <= r_data;
                        r_out_valid <= 8'b1 << w_tgt;
                        r_en        <= 1'b1;
                        r_state     <= StSend;
                    end else if (r_mode) begin
                        // Addressed word to a disabled channel is dropped and counted.
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= StIdle;
                    end
                end
                StSend: begin
                    if (i_ch_ready[r_sel]) begin
                        r_rr_ptr    <= r_sel + 3'd1;
                        r_out_valid <= '0;
                        r_en        <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_sel       = r_sel;
    assign o_en        = r_en;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed scenarios plus randomized words, checked against a
// transaction-level model of channel choice, pointer advance and drop counting.
module tb_demux_rr_sched;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_sel = '0;
    logic          mode = 1'b0;
    logic [7:0]    ch_mask = 8'hFF;
    logic [7:0]    ch_ready = 8'hFF;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    sel;
    logic          en;
    logic          busy;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    int         m_ptr = 0;
    int         m_err = 0;
    logic [7:0] m_last_data = '0;
    logic [2:0] m_last_sel = '0;

    demux_rr_sched #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_sel    (in_sel),
        .i_mode      (mode),
        .i_ch_mask   (ch_mask),
        .i_ch_ready  (ch_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_sel       (sel),
        .o_en        (en),
        .o_busy      (busy),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [7:0] mask, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word from IDLE to completion; called and returning on a falling edge.
    task automatic xfer(input logic [7:0] d, input logic [2:0] s, input logic m,
                        input logic [7:0] mask, input int stall, input int arb_wait);
        int         ch;
        logic       drop;
        logic [7:0] r;
        ch   = m ? int'(s) : rr_pick(mask, m_ptr);
        drop = m && !mask[s];
        if (ch < 0) begin
            errors++;
            $display("FAIL xfer_setup: observed no eligible channel expected a grant");
            $fatal(1, "unusable stimulus");
        end
        chk("idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        mode     = m;
        ch_mask  = (arb_wait > 0) ? 8'h00 : mask;
        ch_ready = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sel   = 3'($urandom);
        mode     = 1'($urandom);
        chk("arb_busy", 32'(busy), 32'd1);
        chk("arb_ready", 32'(in_ready), 32'd0);
        chk("arb_valid", 32'(out_valid), 32'd0);
        chk("arb_data_hold", 32'(out_data), 32'(m_last_data));
        for (int k = 0; k < arb_wait; k++) begin
            @(negedge clk);
            chk("noelig_busy", 32'(busy), 32'd1);
            chk("noelig_ready", 32'(in_ready), 32'd0);
            chk("noelig_valid", 32'(out_valid), 32'd0);
        end
        ch_mask = mask;
        @(negedge clk);
        if (drop) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            chk("drop_valid", 32'(out_valid), 32'd0);
            chk("drop_en", 32'(en), 32'd0);
            chk("drop_ready", 32'(in_ready), 32'd1);
            chk("drop_err", 32'(err_cnt), 32'(m_err));
            chk("drop_sel", 32'(sel), 32'(m_last_sel));
            chk("drop_data", 32'(out_data), 32'(m_last_data));
            return;
        end
        for (int k = 0; k <= stall; k++) begin
            r = 8'($urandom);
            r[ch] = (k == stall);
            ch_ready = r;
            ch_mask  = 8'($urandom);
            chk("send_valid", 32'(out_valid), 32'd1 << ch);
            chk("send_data", 32'(out_data), 32'(d));
            chk("send_sel", 32'(sel), 32'(ch));
            chk("send_en", 32'(en), 32'd1);
            chk("send_ready", 32'(in_ready), 32'd0);
            chk("send_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        m_ptr       = (ch + 1) % 8;
        m_last_data = d;
        m_last_sel  = 3'(ch);
        ch_ready    = 8'hFF;
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_en", 32'(en), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_data", 32'(out_data), 32'(d));
        chk("done_sel", 32'(sel), 32'(ch));
        chk("done_err", 32'(err_cnt), 32'(m_err));
    endtask

    initial begin
        logic [7:0] rmask;
        logic       rm;
        int         rb;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back round-robin over all channels, then wrap to channel 0.
        for (int i = 0; i < 8; i++) xfer(8'h10 + 8'(i), 3'd0, 1'b0, 8'hFF, 0, 0);
        xfer(8'h18, 3'd0, 1'b0, 8'hFF, 0, 0);
        chk("rr_wrap_sel", 32'(sel), 32'd0);

        for (int i = 0; i < 4; i++) xfer(8'h20 + 8'(i), 3'd0, 1'b0, 8'b1010_0100, 0, 0);
        chk("masked_last_sel", 32'(sel), 32'd2);

        xfer(8'hAB, 3'd3, 1'b1, 8'hFF, 0, 0);
        chk("addr_sel", 32'(sel), 32'd3);
        xfer(8'h66, 3'd6, 1'b1, 8'hBF, 0, 0);
        chk("first_drop_err", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 300; i++) xfer(8'($urandom), 3'd6, 1'b1, 8'hBF, 0, 0);
        chk("err_saturated", 32'(err_cnt), 32'd255);

        xfer(8'h3C, 3'd0, 1'b0, 8'hFF, 5, 0);

        xfer(8'h77, 3'd0, 1'b0, 8'h10, 0, 3);
        chk("noelig_grant", 32'(sel), 32'd4);

        for (int i = 0; i < 40; i++) begin
            rm    = 1'($urandom);
            rmask = 8'($urandom);
            if (!rm && rmask == 8'h00) begin
                rb = $urandom_range(7, 0);
                rmask[rb] = 1'b1;
            end
            xfer(8'($urandom), 3'($urandom), rm, rmask, $urandom_range(3, 0), 0);
        end

        // Asynchronous reset while channel 2 is being offered a word.
        ch_mask  = 8'h04;
        mode     = 1'b0;
        in_data  = 8'h5A;
        ch_ready = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_send_valid", 32'(out_valid), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_en", 32'(en), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_err", 32'(err_cnt), 32'd0);
        m_ptr       = 0;
        m_err       = 0;
        m_last_data = '0;
        m_last_sel  = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        ch_ready = 8'hFF;
        xfer(8'hC3, 3'd5, 1'b0, 8'hFF, 0, 0);
        chk("post_rst_sel", 32'(sel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
